// File: rtl/maze_level_nav_if.sv
// Handshake, config and status bundle for maze_level_nav.
// MAZE_STEP_CNT_EN adds the step_count signal.
interface maze_level_nav_if #(
   parameter int unsigned ROW_W = 3,
   parameter int unsigned COL_W = 3,
   parameter int unsigned LVL_W = 1
`ifdef MAZE_STEP_CNT_EN
   , parameter int unsigned STEP_W = 10
`endif
);
   logic             restart;
   logic             move_valid;
   logic [1:0]       move_dir;
   logic             move_ready;
   logic             cfg_we;
   logic [LVL_W-1:0] cfg_lvl;
   logic [ROW_W-1:0] cfg_row;
   logic [COL_W-1:0] cfg_col;
   logic [3:0]       cfg_walls;
   logic [ROW_W-1:0] player_row;
   logic [COL_W-1:0] player_col;
   logic [LVL_W-1:0] level;
   logic [3:0]       cur_walls;
   logic             move_done;
   logic             bump;
   logic             goal;
   logic             game_done;
`ifdef MAZE_STEP_CNT_EN
   logic [STEP_W-1:0] step_count;
`endif

   modport slave (
      input  restart, move_valid, move_dir, cfg_we, cfg_lvl, cfg_row, cfg_col, cfg_walls,
      output move_ready, player_row, player_col, level, cur_walls,
             move_done, bump, goal, game_done
`ifdef MAZE_STEP_CNT_EN
      , output step_count
`endif
   );

   modport master (
      output restart, move_valid, move_dir, cfg_we, cfg_lvl, cfg_row, cfg_col, cfg_walls,
      input  move_ready, player_row, player_col, level, cur_walls,
             move_done, bump, goal, game_done
`ifdef MAZE_STEP_CNT_EN
      , input step_count
`endif
   );
endinterface

// File: rtl/maze_level_nav.sv
// Multi-level maze engine: run-time wall tables, move checking, goal and level advance.
// Optional saturating step counter enabled by MAZE_STEP_CNT_EN.
module maze_level_nav #(
   parameter int unsigned NUM_ROWS   = 5,
   parameter int unsigned NUM_COLS   = 5,
   parameter int unsigned NUM_LEVELS = 2,
   parameter int unsigned ROW_W      = 3,
   parameter int unsigned COL_W      = 3,
   parameter int unsigned LVL_W      = 1,
   parameter int unsigned START_ROW  = 0,
   parameter int unsigned START_COL  = 0,
   parameter int unsigned GOAL_ROW   = 4,
   parameter int unsigned GOAL_COL   = 4
`ifdef MAZE_STEP_CNT_EN
   , parameter int unsigned STEP_W   = 10
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   maze_level_nav_if.slave    bus
);
   localparam int unsigned DEPTH = NUM_LEVELS * NUM_ROWS * NUM_COLS;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_APPLY, S_DONE} state_t;

   function automatic logic in_range(input int unsigned l, input int unsigned r,
                                     input int unsigned c);
      return (l < NUM_LEVELS) && (r < NUM_ROWS) && (c < NUM_COLS);
   endfunction

   function automatic logic [IDX_W-1:0] cell_idx(input int unsigned l, input int unsigned r,
                                                 input int unsigned c);
      return IDX_W'((l * NUM_ROWS + r) * NUM_COLS + c);
   endfunction

   logic [3:0]       r_mem [DEPTH];
   state_t           r_state, w_state_nxt;
   logic [ROW_W-1:0] r_row, w_row_nxt, w_new_row;
   logic [COL_W-1:0] r_col, w_col_nxt, w_new_col;
   logic [LVL_W-1:0] r_level, w_level_nxt;
   logic [1:0]       r_dir, w_dir_nxt;
   logic [3:0]       r_wall_q, w_wall_q_nxt;
   logic             r_advance, w_advance_nxt;
   logic             r_game_done, w_game_done_nxt;
   logic             r_move_done, w_move_done_nxt;
   logic             r_bump, w_bump_nxt;
   logic             r_goal, w_goal_nxt;
   logic             r_move_ready, w_move_ready_nxt;
   logic             w_blocked;
   logic             w_is_goal;
   logic             w_last_lvl;
   logic [3:0]       w_cur_walls;
`ifdef MAZE_STEP_CNT_EN
   logic [STEP_W-1:0] r_step, w_step_nxt;
`endif

   // Wall table: no reset, writes outside the maze are dropped
   always_ff @(posedge clk) begin
      if (bus.cfg_we && in_range(32'(bus.cfg_lvl), 32'(bus.cfg_row), 32'(bus.cfg_col)))
         r_mem[cell_idx(32'(bus.cfg_lvl), 32'(bus.cfg_row), 32'(bus.cfg_col))] <= bus.cfg_walls;
   end

   assign w_cur_walls = in_range(32'(r_level), 32'(r_row), 32'(r_col))
                        ? r_mem[cell_idx(32'(r_level), 32'(r_row), 32'(r_col))] : 4'b0000;

   // Candidate cell and blocking decision for the latched direction
   always_comb begin
      w_new_row = r_row;
      w_new_col = r_col;
      w_blocked = 1'b0;
      unique case (r_dir)
         2'b00: begin
            w_new_row = r_row - ROW_W'(1);
            w_blocked = r_wall_q[3] || (r_row == '0);
         end
         2'b01: begin
            w_new_row = r_row + ROW_W'(1);
            w_blocked = r_wall_q[2] || (32'(r_row) == NUM_ROWS - 1);
         end
         2'b10: begin
            w_new_col = r_col - COL_W'(1);
            w_blocked = r_wall_q[1] || (r_col == '0);
         end
         2'b11: begin
            w_new_col = r_col + COL_W'(1);
            w_blocked = r_wall_q[0] || (32'(r_col) == NUM_COLS - 1);
         end
      endcase
   end

   assign w_is_goal  = (w_new_row == ROW_W'(GOAL_ROW)) && (w_new_col == COL_W'(GOAL_COL));
   assign w_last_lvl = (32'(r_level) == NUM_LEVELS - 1);

   // Next-state and registered-output logic
   always_comb begin
      w_state_nxt      = r_state;
      w_row_nxt        = r_row;
      w_col_nxt        = r_col;
      w_level_nxt      = r_level;
      w_dir_nxt        = r_dir;
      w_wall_q_nxt     = r_wall_q;
      w_advance_nxt    = 1'b0;
      w_game_done_nxt  = r_game_done;
      w_move_done_nxt  = 1'b0;
      w_bump_nxt       = 1'b0;
      w_goal_nxt       = 1'b0;
`ifdef MAZE_STEP_CNT_EN
      w_step_nxt       = r_step;
`endif
      if (bus.restart) begin
         // Restart wins in every state and aborts any move in flight
         w_state_nxt     = S_IDLE;
         w_row_nxt       = ROW_W'(START_ROW);
         w_col_nxt       = COL_W'(START_COL);
         w_level_nxt     = '0;
         w_game_done_nxt = 1'b0;
`ifdef MAZE_STEP_CNT_EN
         w_step_nxt      = '0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (r_advance) begin
                  w_row_nxt   = ROW_W'(START_ROW);
                  w_col_nxt   = COL_W'(START_COL);
                  w_level_nxt = r_level + LVL_W'(1);
`ifdef MAZE_STEP_CNT_EN
                  w_step_nxt  = '0;
`endif
               end
               if (bus.move_valid) begin
                  w_dir_nxt   = bus.move_dir;
                  w_state_nxt = S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               w_wall_q_nxt = w_cur_walls;
               w_state_nxt  = S_APPLY;
            end
            S_APPLY: begin
               w_state_nxt = S_IDLE;
               if (w_blocked) begin
                  w_bump_nxt = 1'b1;
               end else begin
                  w_row_nxt       = w_new_row;
                  w_col_nxt       = w_new_col;
                  w_move_done_nxt = 1'b1;
`ifdef MAZE_STEP_CNT_EN
                  if (r_step != '1) w_step_nxt = r_step + STEP_W'(1);
`endif
                  if (w_is_goal) begin
                     w_goal_nxt = 1'b1;
                     if (w_last_lvl) begin
                        w_game_done_nxt = 1'b1;
                        w_state_nxt     = S_DONE;
                     end else begin
                        w_advance_nxt = 1'b1;
                     end
                  end
               end
            end
            S_DONE: begin
               w_state_nxt = S_DONE;
            end
         endcase
      end
      w_move_ready_nxt = (w_state_nxt == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_row        <= ROW_W'(START_ROW);
         r_col        <= COL_W'(START_COL);
         r_level      <= '0;
         r_dir        <= 2'b00;
         r_wall_q     <= 4'b0000;
         r_advance    <= 1'b0;
         r_game_done  <= 1'b0;
         r_move_done  <= 1'b0;
         r_bump       <= 1'b0;
         r_goal       <= 1'b0;
         r_move_ready <= 1'b1;
`ifdef MAZE_STEP_CNT_EN
         r_step       <= '0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_row        <= w_row_nxt;
         r_col        <= w_col_nxt;
         r_level      <= w_level_nxt;
         r_dir        <= w_dir_nxt;
         r_wall_q     <= w_wall_q_nxt;
         r_advance    <= w_advance_nxt;
         r_game_done  <= w_game_done_nxt;
         r_move_done  <= w_move_done_nxt;
         r_bump       <= w_bump_nxt;
         r_goal       <= w_goal_nxt;
         r_move_ready <= w_move_ready_nxt;
`ifdef MAZE_STEP_CNT_EN
         r_step       <= w_step_nxt;
`endif
      end
   end

   assign bus.move_ready = r_move_ready;
   assign bus.player_row = r_row;
   assign bus.player_col = r_col;
   assign bus.level      = r_level;
   assign bus.cur_walls  = w_cur_walls;
   assign bus.move_done  = r_move_done;
   assign bus.bump       = r_bump;
   assign bus.goal       = r_goal;
   assign bus.game_done  = r_game_done;
`ifdef MAZE_STEP_CNT_EN
   assign bus.step_count = r_step;
`endif
endmodule

// File: tb/tb_maze_level_nav.sv
// Scoreboard bench for maze_level_nav: directed moves queue expected pulses, a monitor checks them.
module tb_maze_level_nav;
   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   typedef struct {
      logic       bump;
      logic       goal;
      logic [2:0] row;
      logic [2:0] col;
      logic       lvl;
      logic       gd;
      int         due;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   maze_level_nav_if #(.ROW_W(3), .COL_W(3), .LVL_W(1)) bus ();

   maze_level_nav #(
      .NUM_ROWS(5), .NUM_COLS(5), .NUM_LEVELS(2), .ROW_W(3), .COL_W(3), .LVL_W(1),
      .START_ROW(0), .START_COL(0), .GOAL_ROW(4), .GOAL_COL(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every result pulse must match the oldest queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && (bus.move_done === 1'b1 || bus.bump === 1'b1)) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_pulse: done=%b bump=%b at (%0d,%0d) lvl %0d, none expected",
                        bus.move_done, bus.bump, bus.player_row, bus.player_col, bus.level);
            end else begin
               e = q.pop_front();
               if (bus.bump !== e.bump || bus.move_done !== !e.bump || bus.goal !== e.goal ||
                   bus.player_row !== e.row || bus.player_col !== e.col ||
                   bus.level !== e.lvl || bus.game_done !== e.gd || cyc != e.due) begin
                  n_fail++;
                  $display("FAIL move_result: got bump=%b done=%b goal=%b pos=(%0d,%0d) lvl=%0d gd=%b cyc=%0d; expected bump=%b goal=%b pos=(%0d,%0d) lvl=%0d gd=%b cyc=%0d",
                           bus.bump, bus.move_done, bus.goal, bus.player_row, bus.player_col,
                           bus.level, bus.game_done, cyc, e.bump, e.goal, e.row, e.col,
                           e.lvl, e.gd, e.due);
               end
            end
         end
      end
   end

   task automatic cfg_write(input int l, input int r, input int c, input logic [3:0] w);
      bus.cfg_we    = 1'b1;
      bus.cfg_lvl   = 1'(l);
      bus.cfg_row   = 3'(r);
      bus.cfg_col   = 3'(c);
      bus.cfg_walls = w;
      @(negedge clk);
      bus.cfg_we = 1'b0;
   endtask

   // Issue one move at a negedge; result pulse is due two edges after the accept edge
   task automatic do_move(input logic [1:0] dir, input logic bmp, input logic gl,
                          input int row, input int col, input int lvl, input logic gd);
      int k = 0;
      exp_t e;
      while (bus.move_ready !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (bus.move_ready !== 1'b1) begin
         check("ready_timeout", 32'(bus.move_ready), 32'd1);
         return;
      end
      e.bump = bmp; e.goal = gl; e.row = 3'(row); e.col = 3'(col);
      e.lvl = 1'(lvl); e.gd = gd; e.due = cyc + 3;
      q.push_back(e);
      bus.move_valid = 1'b1;
      bus.move_dir   = dir;
      @(negedge clk);
      bus.move_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   localparam logic [1:0] UP = 2'b00, DN = 2'b01, LF = 2'b10, RT = 2'b11;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      bus.restart = 1'b0; bus.move_valid = 1'b0; bus.move_dir = 2'b00;
      bus.cfg_we = 1'b0; bus.cfg_lvl = '0; bus.cfg_row = '0; bus.cfg_col = '0; bus.cfg_walls = '0;
      repeat (3) @(negedge clk);
      check("rst_row", 32'(bus.player_row), 0);
      check("rst_col", 32'(bus.player_col), 0);
      check("rst_level", 32'(bus.level), 0);
      check("rst_game_done", 32'(bus.game_done), 0);
      check("rst_pulses", 32'({bus.move_done, bus.bump, bus.goal}), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(bus.move_ready), 1);

      for (int l = 0; l < 2; l++)
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
               cfg_write(l, r, c, 4'b0000);
      cfg_write(0, 5, 0, 4'b1111);      // out of range row: must not alias level 1 (0,0)
      cfg_write(0, 0, 0, 4'b1110);
      check("cur_walls_l0_00", 32'(bus.cur_walls), 32'h0000_000E);

      // Walls and boundaries around the start cell
      do_move(RT, 0, 0, 0, 1, 0, 0);
      do_move(LF, 0, 0, 0, 0, 0, 0);
      do_move(UP, 1, 0, 0, 0, 0, 0);
      do_move(DN, 1, 0, 0, 0, 0, 0);
      cfg_write(0, 0, 0, 4'b0000);
      do_move(UP, 1, 0, 0, 0, 0, 0);
      do_move(LF, 1, 0, 0, 0, 0, 0);

      // Level 0 run to the goal
      for (int i = 1; i <= 4; i++) do_move(DN, 0, 0, i, 0, 0, 0);
      for (int i = 1; i <= 3; i++) do_move(RT, 0, 0, 4, i, 0, 0);
      do_move(RT, 0, 1, 4, 4, 0, 0);
      @(negedge clk);
      check("adv_level", 32'(bus.level), 1);
      check("adv_pos", 32'({bus.player_row, bus.player_col}), 0);
      check("oor_write_ignored", 32'(bus.cur_walls), 0);

      // Level 1 (last) with a bottom wall at (2,0)
      cfg_write(1, 2, 0, 4'b0100);
      do_move(DN, 0, 0, 1, 0, 1, 0);
      do_move(DN, 0, 0, 2, 0, 1, 0);
      do_move(DN, 1, 0, 2, 0, 1, 0);
      do_move(RT, 0, 0, 2, 1, 1, 0);
      do_move(DN, 0, 0, 3, 1, 1, 0);
      do_move(DN, 0, 0, 4, 1, 1, 0);
      do_move(RT, 0, 0, 4, 2, 1, 0);
      do_move(RT, 0, 0, 4, 3, 1, 0);
      do_move(RT, 0, 1, 4, 4, 1, 1);
      @(negedge clk);
      check("done_ready_low", 32'(bus.move_ready), 0);
      check("done_game_done", 32'(bus.game_done), 1);
      check("done_level", 32'(bus.level), 1);
      check("done_pos", 32'({bus.player_row, bus.player_col}), 32'({3'd4, 3'd4}));
      bus.move_valid = 1'b1; bus.move_dir = UP;
      repeat (4) @(negedge clk);
      bus.move_valid = 1'b0;
      check("done_ignores_pos", 32'({bus.player_row, bus.player_col}), 32'({3'd4, 3'd4}));
      check("done_ignores_ready", 32'(bus.move_ready), 0);
      bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
      check("restart_level", 32'(bus.level), 0);
      check("restart_pos", 32'({bus.player_row, bus.player_col}), 0);
      check("restart_game_done", 32'(bus.game_done), 0);
      check("restart_ready", 32'(bus.move_ready), 1);

      // Restart during LOOKUP aborts the move from (2,2)
      do_move(DN, 0, 0, 1, 0, 0, 0);
      do_move(DN, 0, 0, 2, 0, 0, 0);
      do_move(RT, 0, 0, 2, 1, 0, 0);
      do_move(RT, 0, 0, 2, 2, 0, 0);
      bus.move_valid = 1'b1; bus.move_dir = DN;
      @(negedge clk);
      bus.move_valid = 1'b0; bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
      check("abort_pos", 32'({bus.player_row, bus.player_col}), 0);
      check("abort_level", 32'(bus.level), 0);
      check("abort_ready", 32'(bus.move_ready), 1);
      check("abort_pulses", 32'({bus.move_done, bus.bump, bus.goal}), 0);
      repeat (4) @(negedge clk);

      // Step counting path, then level 0 goal again
      do_move(UP, 1, 0, 0, 0, 0, 0);
      do_move(RT, 0, 0, 0, 1, 0, 0);
      do_move(RT, 0, 0, 0, 2, 0, 0);
      do_move(DN, 0, 0, 1, 2, 0, 0);
`ifdef MAZE_STEP_CNT_EN
      check("step_count_3", 32'(bus.step_count), 3);
`endif
      for (int i = 2; i <= 4; i++) do_move(DN, 0, 0, i, 2, 0, 0);
      do_move(RT, 0, 0, 4, 3, 0, 0);
      do_move(RT, 0, 1, 4, 4, 0, 0);
      @(negedge clk);
      check("adv2_level", 32'(bus.level), 1);
`ifdef MAZE_STEP_CNT_EN
      check("step_count_clr", 32'(bus.step_count), 0);
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/maze_level_nav.md
Name: maze_level_nav

Overview:
Parametrised multi-level maze engine. It is the successor to the fixed 5x5 single-level wall table.
- Stores wall tables for NUM_LEVELS levels, loaded at run time through a config write port.
- Tracks the player cell and accepts move requests over a valid/ready handshake.
- Checks each move against the walls and the maze bounds, detects the goal cell, and advances levels.
- Feeds the renderer (position, current walls) and the game controller (pulses, done flag).

Parameters:
NUM_ROWS, 5, maze rows per level
NUM_COLS, 5, maze columns per level
NUM_LEVELS, 2, number of stored levels
ROW_W, 3, row index width (2^ROW_W >= NUM_ROWS)
COL_W, 3, column index width (2^COL_W >= NUM_COLS)
LVL_W, 1, level index width (2^LVL_W >= NUM_LEVELS)
START_ROW, 0, start cell row, all levels
START_COL, 0, start cell column, all levels
GOAL_ROW, 4, goal cell row, all levels
GOAL_COL, 4, goal cell column, all levels
STEP_W, 10, step counter width (optional feature only)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
restart  in  1  return to level 0 start cell; clears done
move_valid  in  1  move request valid
move_dir  in  2  direction: 00 up, 01 down, 10 left, 11 right
move_ready  out  1  move request can be accepted
cfg_we  in  1  wall table write enable
cfg_lvl  in  LVL_W  write level index
cfg_row  in  ROW_W  write row index
cfg_col  in  COL_W  write column index
cfg_walls  in  4  wall bits {T,B,L,R}
player_row  out  ROW_W  current player row
player_col  out  COL_W  current player column
level  out  LVL_W  current level
cur_walls  out  4  walls of the current cell (combinational read)
move_done  out  1  one-cycle pulse: move applied
bump  out  1  one-cycle pulse: move blocked
goal  out  1  one-cycle pulse: goal reached
game_done  out  1  high after the last level is completed

Behaviour:
- Reset (async assert, sync release):
  - FSM to IDLE.
  - player_row=START_ROW, player_col=START_COL, level=0.
  - All pulses 0, game_done=0, move_ready=1 once released.
  - Wall table is NOT cleared by reset.
- Wall table:
  - NUM_LEVELS*NUM_ROWS*NUM_COLS entries of 4 bits {T,B,L,R}.
  - cfg_we writes on the clock edge; the value is visible from the next cycle.
  - Out-of-range lvl/row/col writes are ignored.
  - cfg writes are allowed in any state.
  - cur_walls reads 0 when the current position is out of range.
- FSM states: IDLE, LOOKUP, APPLY, DONE.
  - IDLE: move_ready=1.
    - restart has priority: go to level 0 start, stay IDLE.
    - Else, if move_valid: latch move_dir, go to LOOKUP.
  - LOOKUP: move_ready=0. Register the walls of the current cell into wall_q.
  - APPLY: move_ready=0. A move is blocked if:
    - up: wall_q[3] or row==0
    - down: wall_q[2] or row==NUM_ROWS-1
    - left: wall_q[1] or col==0
    - right: wall_q[0] or col==NUM_COLS-1
  - APPLY outcomes:
    - Blocked: pulse bump; position unchanged; go to IDLE.
    - Not blocked: update position, pulse move_done.
    - If the new cell is (GOAL_ROW,GOAL_COL), also pulse goal in the same cycle:
      - Not last level: level+1 and position=start in the following cycle, then IDLE.
      - level==NUM_LEVELS-1: position stays at goal, level holds, game_done=1, go to DONE.
  - DONE: move_ready=0, requests ignored. restart returns to IDLE at level 0 start and clears game_done.
- Latency: accept at edge N, result pulse at edge N+2; next accept possible at edge N+3.
- restart in LOOKUP or APPLY:
  - Aborts the in-flight move: no pulses, position to level 0 start, go to IDLE.
- A cfg write to the current cell in the same cycle as LOOKUP does not affect that lookup; the old value is used.
- move_valid held high while move_ready=0 is not accepted. The requester holds it until the handshake.

Optional Feature:
MAZE_STEP_CNT_EN:
- Defined: adds output step_count[STEP_W-1:0].
  - Increments on every move_done, saturating at all-ones.
  - Cleared by reset, restart, and level advance.
  - bump does not increment it.
- Undefined: no step_count port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset, then write level 0 cell (0,0)={1,1,1,0}; move right -> move_done at N+2, player=(0,1), no bump.
- From (0,0), move up -> bump at N+2, position stays (0,0); with cell (0,0)=0000, move left -> bump (boundary).
- Level 0 path with walls all 0000: 4 downs then 4 rights to (4,4) -> goal pulse with move_done, then level=1, player=(0,0).
- Reach the goal on level 1 (last level) -> goal pulse, game_done=1, move_ready=0; move request ignored; restart -> level=0, (0,0), game_done=0.
- Assert restart in the LOOKUP cycle of a move from (2,2) -> no move_done/bump, player=(0,0), level=0, IDLE next cycle.
- With MAZE_STEP_CNT_EN: 3 moves plus 1 bump -> step_count=3; goal on level 0 -> step_count=0.
